// File: rtl/fp_add_normalizer_if.sv
// rtl/fp_add_normalizer_if.sv - upstream/downstream handshake bundle for fp_add_normalizer
interface fp_add_normalizer_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [EXP_W-1:0]        in_exp;
    logic [MANT_W+1:0]       in_mant;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+MANT_W:0]   out_result;
    logic                    out_ovf;
    logic                    out_unf;
    logic                    out_zero;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf, out_zero
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf, out_zero
    );
endinterface

// File: rtl/fp_add_normalizer.sv
// rtl/fp_add_normalizer.sv - post-add significand normaliser with packed single-precision output
// Optional round-to-nearest-even on the carry right shift: FP_NORM_ROUND_NEAREST_EN
module fp_add_normalizer #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_add_normalizer_if.slave   bus
);
    localparam int MW = MANT_W + 2;
    localparam logic [EXP_W:0] EXP_MAX = (EXP_W+1)'((1 << EXP_W) - 1);
    localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_sign, w_sign_nxt;
    logic [EXP_W:0]   r_exp, w_exp_nxt;
    logic [MW-1:0]    r_mant, w_mant_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_unf, w_unf_nxt;
    logic             r_zero, w_zero_nxt;

    logic [MW-1:0]    w_shr;
    logic [MW-1:0]    w_rshift_mant;
    logic [EXP_W:0]   w_rshift_exp;

    assign w_shr = {1'b0, r_mant[MW-1:1]};

`ifdef FP_NORM_ROUND_NEAREST_EN
    // Dropped bit is exactly half an ulp, so only the tie-to-even case rounds up.
    logic             w_round;
    logic [MW-1:0]    w_rnd_sum;
    assign w_round   = r_mant[0] & r_mant[1];
    assign w_rnd_sum = w_shr + MW'(w_round);
    assign w_rshift_mant = w_rnd_sum[MW-1] ? {1'b0, w_rnd_sum[MW-1:1]} : w_rnd_sum;
    assign w_rshift_exp  = w_rnd_sum[MW-1] ? (r_exp + EXP_ONE + EXP_ONE) : (r_exp + EXP_ONE);
`else
    assign w_rshift_mant = w_shr;
    assign w_rshift_exp  = r_exp + EXP_ONE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_mant <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            r_sign <= w_sign_nxt;
            r_exp  <= w_exp_nxt;
            r_mant <= w_mant_nxt;
            r_ovf  <= w_ovf_nxt;
            r_unf  <= w_unf_nxt;
            r_zero <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sign_nxt  = r_sign;
        w_exp_nxt   = r_exp;
        w_mant_nxt  = r_mant;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_zero_nxt  = r_zero;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = S_NORM;
                    w_sign_nxt  = bus.in_sign;
                    w_exp_nxt   = {1'b0, bus.in_exp};
                    w_mant_nxt  = bus.in_mant;
                    w_ovf_nxt   = 1'b0;
                    w_unf_nxt   = 1'b0;
                    w_zero_nxt  = 1'b0;
                end
            end
            S_NORM: begin
                // One normalisation decision per edge; only the left shift stays here.
                if (r_exp == EXP_MAX) begin
                    w_state_nxt = S_DONE;
                end else if (r_mant[MW-1]) begin
                    w_state_nxt = S_DONE;
                    if (w_rshift_exp >= EXP_MAX) begin
                        w_exp_nxt  = EXP_MAX;
                        w_mant_nxt = '0;
                        w_ovf_nxt  = 1'b1;
                    end else begin
                        w_exp_nxt  = w_rshift_exp;
                        w_mant_nxt = w_rshift_mant;
                    end
                end else if (r_mant == '0) begin
                    w_state_nxt = S_DONE;
                    w_sign_nxt  = 1'b0;
                    w_exp_nxt   = '0;
                    w_zero_nxt  = 1'b1;
                end else if (r_mant[MANT_W]) begin
                    w_state_nxt = S_DONE;
                end else if (r_exp <= EXP_ONE) begin
                    w_state_nxt = S_DONE;
                    w_exp_nxt   = '0;
                    w_mant_nxt  = '0;
                    w_unf_nxt   = 1'b1;
                    w_zero_nxt  = 1'b1;
                end else begin
                    w_mant_nxt  = {r_mant[MW-2:0], 1'b0};
                    w_exp_nxt   = r_exp - EXP_ONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are forced to zero outside DONE so reset and idle look identical downstream.
    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.out_result = (r_state == S_DONE) ? {r_sign, r_exp[EXP_W-1:0], r_mant[MANT_W-1:0]} : '0;
    assign bus.out_ovf    = (r_state == S_DONE) & r_ovf;
    assign bus.out_unf    = (r_state == S_DONE) & r_unf;
    assign bus.out_zero   = (r_state == S_DONE) & r_zero;
endmodule

// File: tb/tb_fp_add_normalizer.sv
// tb/tb_fp_add_normalizer.sv - directed-vector bench for fp_add_normalizer with a closed-form reference model
module tb_fp_add_normalizer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_add_normalizer_if u_if();

    fp_add_normalizer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    int          checks = 0;
    int          errors = 0;
    logic        exp_active = 1'b0;
    logic [31:0] exp_res = '0;
    logic [2:0]  exp_fl = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // Closed form: locate the leading one, then decide shift count / underflow point directly.
    function automatic void model(input logic s, input int e, input logic [24:0] mm,
                                  output logic [31:0] res, output logic [2:0] fl, output int lat);
        int          q;
        int          e2;
        int          p;
        int          sn;
        logic [24:0] sh;
        logic [31:0] qv;
        logic [31:0] ev;
        lat = 2;
        fl  = 3'b000;
        res = '0;
        if (e == 255) begin
            res = {s, 8'hFF, mm[22:0]};
        end else if (mm[24]) begin
            q  = int'(mm) / 2;
            e2 = e + 1;
`ifdef FP_NORM_ROUND_NEAREST_EN
            if (mm[0] && (q % 2 == 1)) q = q + 1;
            if (q >= 32'h0100_0000) begin
                q  = q / 2;
                e2 = e2 + 1;
            end
`endif
            if (e2 >= 255) begin
                res = {s, 8'hFF, 23'b0};
                fl  = 3'b100;
            end else begin
                qv  = q;
                ev  = e2;
                res = {s, ev[7:0], qv[22:0]};
            end
        end else if (mm == 25'd0) begin
            res = '0;
            fl  = 3'b001;
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (mm[i]) p = i;
            sn = 23 - p;
            if (sn == 0 || e - sn >= 1) begin
                sh  = mm << sn;
                ev  = e - sn;
                res = {s, ev[7:0], sh[22:0]};
                lat = 2 + sn;
            end else begin
                lat = 2 + ((e <= 1) ? 0 : e - 1);
                res = {s, 31'b0};
                fl  = 3'b011;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && u_if.out_valid) begin
            if (!exp_active) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("cmp_result", u_if.out_result, exp_res);
                check("cmp_flags", {29'b0, u_if.out_ovf, u_if.out_unf, u_if.out_zero}, {29'b0, exp_fl});
            end
        end
    end

    task automatic run(input string name, input logic s, input int e, input logic [24:0] m,
                       input logic [31:0] lit, input logic [2:0] lfl, input int hold);
        logic [31:0] mres;
        logic [2:0]  mfl;
        int          mlat;
        int          n;
        logic [31:0] ev;
        model(s, e, m, mres, mfl, mlat);
        check({name, "_model_res"}, mres, lit);
        check({name, "_model_flags"}, {29'b0, mfl}, {29'b0, lfl});
        exp_res = mres;
        exp_fl  = mfl;
        ev = e;
        check({name, "_in_ready_idle"}, 32'(u_if.in_ready), 32'd1);
        u_if.in_valid = 1'b1;
        u_if.in_sign  = s;
        u_if.in_exp   = ev[7:0];
        u_if.in_mant  = m;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        exp_active = 1'b1;
        n = 1;
        while (!u_if.out_valid && n < 40) begin
            check({name, "_in_ready_busy"}, 32'(u_if.in_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, mlat);
        check({name, "_result"}, u_if.out_result, lit);
        check({name, "_flags"}, {29'b0, u_if.out_ovf, u_if.out_unf, u_if.out_zero}, {29'b0, lfl});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_valid"}, 32'(u_if.out_valid), 32'd1);
            check({name, "_hold_in_ready"}, 32'(u_if.in_ready), 32'd0);
            check({name, "_hold_result"}, u_if.out_result, lit);
        end
        u_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b0;
        exp_active = 1'b0;
        check({name, "_post_valid"}, 32'(u_if.out_valid), 32'd0);
        check({name, "_post_in_ready"}, 32'(u_if.in_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_valid"}, 32'(u_if.out_valid), 32'd0);
        check({name, "_in_ready"}, 32'(u_if.in_ready), 32'd1);
        check({name, "_result"}, u_if.out_result, 32'd0);
        check({name, "_flags"}, {29'b0, u_if.out_ovf, u_if.out_unf, u_if.out_zero}, 32'd0);
    endtask

    logic [31:0] rnd_lit;

    initial begin
`ifdef FP_NORM_ROUND_NEAREST_EN
        rnd_lit = 32'h4080_0002;
`else
        rnd_lit = 32'h4080_0001;
`endif
        rst_n          = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_sign   = 1'b0;
        u_if.in_exp    = '0;
        u_if.in_mant   = '0;
        u_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("add_1p3",    1'b0, 128, 25'h100_0000, 32'h4080_0000, 3'b000, 0);
        run("neg_sum",    1'b1, 128, 25'h120_0000, 32'hC090_0000, 3'b000, 0);
        run("lshift2",    1'b0, 130, 25'h020_0000, 32'h4000_0000, 3'b000, 0);
        run("zero",       1'b1, 100, 25'h000_0000, 32'h0000_0000, 3'b001, 0);
        run("underflow",  1'b0,   2, 25'h000_0001, 32'h0000_0000, 3'b011, 0);
        run("unf_exp0",   1'b1,   0, 25'h040_0000, 32'h8000_0000, 3'b011, 0);
        run("overflow",   1'b0, 254, 25'h100_0000, 32'h7F80_0000, 3'b100, 0);
        run("ovf_allone", 1'b1, 254, 25'h1FF_FFFF, 32'hFF80_0000, 3'b100, 0);
        run("rounding",   1'b0, 128, 25'h100_0003, rnd_lit,       3'b000, 0);
        run("exp255",     1'b0, 255, 25'h0AB_CDEF, 32'h7FAB_CDEF, 3'b000, 0);
        run("normed",     1'b1, 127, 25'h0C0_0000, 32'hBFC0_0000, 3'b000, 0);
        run("max_lshift", 1'b0, 200, 25'h000_0001, 32'h5880_0000, 3'b000, 0);
        run("backpress",  1'b0, 128, 25'h100_0000, 32'h4080_0000, 3'b000, 5);

        u_if.in_valid = 1'b1;
        u_if.in_sign  = 1'b1;
        u_if.in_exp   = 8'd130;
        u_if.in_mant  = 25'h000_0001;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_reset_state("after_reset");
        run("post_reset", 1'b0, 128, 25'h100_0000, 32'h4080_0000, 3'b000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
